// File: rtl/slv_rsp_scheduler.sv
// Round-robin arbiter sharing one AXI R channel among NREQ response sources.
// Holds the grant for a whole burst, checks payload stability and stalls.
module slv_rsp_scheduler #(
  parameter int NREQ       = 4,
  parameter int AXI_ID_W   = 8,
  parameter int AXI_DATA_W = 8,
  parameter int TIMEOUT    = 100
) (
  input  logic                       aclk,
  input  logic                       aresetn,
  input  logic                       srst,
  input  logic [NREQ-1:0]            req_valid,
  output logic [NREQ-1:0]            req_ready,
  input  logic [NREQ*AXI_ID_W-1:0]   req_id,
  input  logic [NREQ*AXI_DATA_W-1:0] req_data,
  input  logic [NREQ*2-1:0]          req_resp,
  input  logic [NREQ-1:0]            req_last,
  output logic                       rvalid,
  input  logic                       rready,
  output logic [AXI_ID_W-1:0]        rid,
  output logic [AXI_DATA_W-1:0]      rdata,
  output logic [1:0]                 rresp,
  output logic                       rlast,
  output logic [NREQ-1:0]            grant,
  output logic                       error,
  output logic                       timeout
);

  localparam int SW = $clog2(NREQ);

  typedef enum logic {
    IDLE,
    BURST
  } state_t;

  state_t          state_q, state_d;
  logic [SW-1:0]   ptr_q, ptr_d;
  logic [SW-1:0]   sel_q, sel_d;
  logic [NREQ-1:0] grant_q, grant_d;

  logic                  s_valid;
  logic [AXI_ID_W-1:0]   s_id;
  logic [AXI_DATA_W-1:0] s_data;
  logic [1:0]            s_resp;
  logic                  s_last;

  logic [2*NREQ-1:0] rot_dbl;
  logic [NREQ-1:0]   rot;
  logic [SW-1:0]     off;
  logic [SW:0]       win_sum;
  logic [SW-1:0]     win;
  logic              found;

  logic                  hold_q;
  logic [AXI_ID_W-1:0]   h_id_q;
  logic [AXI_DATA_W-1:0] h_data_q;
  logic [1:0]            h_resp_q;
  logic                  h_last_q;
  logic                  viol;
  logic                  error_q;

  logic [31:0] cnt_q, cnt_d;
  logic        timeout_q;

  logic busy, stall, done;

  always_comb begin
    s_valid = 1'b0;
    s_id    = '0;
    s_data  = '0;
    s_resp  = '0;
    s_last  = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (sel_q == SW'(i)) begin
        s_valid = req_valid[i];
        s_id    = req_id[i*AXI_ID_W +: AXI_ID_W];
        s_data  = req_data[i*AXI_DATA_W +: AXI_DATA_W];
        s_resp  = req_resp[i*2 +: 2];
        s_last  = req_last[i];
      end
    end
  end

  // Rotate requests so bit 0 is the pointer position; lowest set bit wins.
  assign rot_dbl = {req_valid, req_valid} >> ptr_q;
  assign rot     = rot_dbl[NREQ-1:0];

  always_comb begin
    off   = '0;
    found = 1'b0;
    for (int k = NREQ-1; k >= 0; k--) begin
      if (rot[k]) begin
        off   = SW'(k);
        found = 1'b1;
      end
    end
  end

  always_comb begin
    win_sum = {1'b0, ptr_q} + {1'b0, off};
    if (win_sum >= (SW+1)'(NREQ)) begin
      win_sum = win_sum - (SW+1)'(NREQ);
    end
    win = win_sum[SW-1:0];
  end

  assign busy   = (state_q == BURST);
  assign rvalid = busy & s_valid;
  assign rid    = rvalid ? s_id   : '0;
  assign rdata  = rvalid ? s_data : '0;
  assign rresp  = rvalid ? s_resp : '0;
  assign rlast  = rvalid & s_last;
  assign stall  = rvalid & ~rready;
  assign done   = rvalid & rready & s_last;

  always_comb begin
    req_ready = '0;
    if (busy) begin
      req_ready = grant_q & {NREQ{rready}};
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    sel_d   = sel_q;
    grant_d = grant_q;
    unique case (state_q)
      IDLE: begin
        if (found) begin
          state_d = BURST;
          sel_d   = win;
          grant_d = NREQ'(1) << win;
        end
      end
      BURST: begin
        if (done) begin
          state_d = IDLE;
          grant_d = '0;
          ptr_d   = (sel_q == SW'(NREQ-1)) ? '0 : sel_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign viol = hold_q & (~s_valid |
                          (s_id   != h_id_q)   |
                          (s_data != h_data_q) |
                          (s_resp != h_resp_q) |
                          (s_last != h_last_q));

  assign cnt_d = stall ? cnt_q + 32'd1 : '0;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q   <= IDLE;
      ptr_q     <= '0;
      sel_q     <= '0;
      grant_q   <= '0;
      hold_q    <= 1'b0;
      h_id_q    <= '0;
      h_data_q  <= '0;
      h_resp_q  <= '0;
      h_last_q  <= 1'b0;
      error_q   <= 1'b0;
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else if (srst) begin
      state_q   <= IDLE;
      ptr_q     <= '0;
      sel_q     <= '0;
      grant_q   <= '0;
      hold_q    <= 1'b0;
      h_id_q    <= '0;
      h_data_q  <= '0;
      h_resp_q  <= '0;
      h_last_q  <= 1'b0;
      error_q   <= 1'b0;
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      sel_q     <= sel_d;
      grant_q   <= grant_d;
      hold_q    <= stall;
      h_id_q    <= s_id;
      h_data_q  <= s_data;
      h_resp_q  <= s_resp;
      h_last_q  <= s_last;
      error_q   <= error_q | viol;
      cnt_q     <= cnt_d;
      timeout_q <= (cnt_d >= 32'(TIMEOUT));
    end
  end

  assign grant   = grant_q;
  assign error   = error_q;
  assign timeout = timeout_q;

endmodule
